// File: rtl/pattern_bank_if.sv
// pattern_bank_if: host port A and row-stream signals of pattern_bank.
//   Port A : wea, addra, dina -> douta (registered read, read-first)
//   Stream : start, pat_sel (+mirror when PATTERN_MIRROR_EN) -> busy,
//            row_valid/row_ready handshake carrying row_idx, row_data; done pulse
// master = host/loader side, slave = pattern_bank.
interface pattern_bank_if #(
  parameter int DATA_W = 128,
  parameter int ROWS   = 32,
  parameter int NPAT   = 32
);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int PSEL_W = $clog2(NPAT);
  localparam int ADDR_W = PSEL_W + ROW_W;

  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;
  logic              start;
  logic [PSEL_W-1:0] pat_sel;
`ifdef PATTERN_MIRROR_EN
  logic              mirror;
`endif
  logic              busy;
  logic              row_valid;
  logic              row_ready;
  logic [ROW_W-1:0]  row_idx;
  logic [DATA_W-1:0] row_data;
  logic              done;

  modport master (
    output wea, addra, dina, start, pat_sel, row_ready,
`ifdef PATTERN_MIRROR_EN
    output mirror,
`endif
    input  douta, busy, row_valid, row_idx, row_data, done
  );

  modport slave (
    input  wea, addra, dina, start, pat_sel, row_ready,
`ifdef PATTERN_MIRROR_EN
    input  mirror,
`endif
    output douta, busy, row_valid, row_idx, row_data, done
  );
endinterface

// File: rtl/pattern_bank.sv
// pattern_bank: NPAT seed patterns of ROWS x DATA_W bits for the Life board.
// Port A is a read-first read/write host port with one cycle read latency.
// Port B is internal: a start request streams one whole pattern row by row
// over a valid/ready handshake, one row per cycle at full throughput.
//   clka : clock, rising edge
//   rsta : asynchronous reset, active high (memory contents are kept)
//   bus  : pattern_bank_if.slave (port A + stream handshake)
// Optional build macro PATTERN_MIRROR_EN adds bus.mirror, captured with
// start; when set, streamed rows are bit-reversed (horizontal flip).
module pattern_bank #(
  parameter int DATA_W = 128,
  parameter int ROWS   = 32,
  parameter int NPAT   = 32
) (
  input logic           clka,
  input logic           rsta,
  pattern_bank_if.slave bus
);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int PSEL_W = $clog2(NPAT);
  localparam int ADDR_W = PSEL_W + ROW_W;
  localparam int DEPTH  = NPAT * ROWS;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, FIN} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------- port A ----------------
  logic [DATA_W-1:0] r_douta;

  always_ff @(posedge clka) begin
    if (bus.wea) r_mem[bus.addra] <= bus.dina;
  end

  // Non-blocking read of the same array gives read-first behaviour.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) r_douta <= '0;
    else      r_douta <= r_mem[bus.addra];
  end

  assign bus.douta = r_douta;

  // ---------------- stream engine ----------------
  state_t            r_state, w_state_nxt;
  logic [PSEL_W-1:0] r_psel;
  logic [ROW_W-1:0]  r_row_idx, w_row_idx_nxt;
  logic              r_row_valid, w_valid_nxt;
  logic [DATA_W-1:0] r_row_data;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_cap, w_rd_en, w_hs;
  logic [ROW_W-1:0]  w_rd_row;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_word;

  assign w_hs = r_row_valid & bus.row_ready;
  // Pattern base is pat_sel*ROWS, so the row index only fills the low bits
  // and the address can never run into the next pattern.
  assign w_rd_addr = {r_psel, w_rd_row};

`ifdef PATTERN_MIRROR_EN
  logic r_mirror;

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    for (int i = 0; i < DATA_W; i++) y[i] = x[DATA_W-1-i];
    return y;
  endfunction

  // Flip happens on the way into the output register: no extra latency.
  assign w_rd_word = r_mirror ? bitrev(r_mem[w_rd_addr]) : r_mem[w_rd_addr];

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta)       r_mirror <= 1'b0;
    else if (w_cap) r_mirror <= bus.mirror;
  end
`else
  assign w_rd_word = r_mem[w_rd_addr];
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    w_valid_nxt   = r_row_valid;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_cap         = 1'b0;
    w_rd_en       = 1'b0;
    w_rd_row      = '0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_cap       = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_rd_en       = 1'b1;
        w_rd_row      = '0;
        w_row_idx_nxt = '0;
        w_valid_nxt   = 1'b1;
        w_state_nxt   = STREAM;
      end
      STREAM: begin
        // Stall (no handshake) issues no read and holds row_data/row_idx.
        if (w_hs) begin
          if (r_row_idx == LAST_ROW) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = FIN;
          end else begin
            w_rd_en       = 1'b1;
            w_rd_row      = r_row_idx + ROW_W'(1);
            w_row_idx_nxt = w_rd_row;
          end
        end
      end
      FIN: begin
        // done is high for this one cycle; busy falls together with it.
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_state     <= IDLE;
      r_psel      <= '0;
      r_row_idx   <= '0;
      r_row_valid <= 1'b0;
      r_row_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_row_valid <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      if (w_cap)   r_psel     <= bus.pat_sel;
      if (w_rd_en) r_row_data <= w_rd_word;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.row_valid = r_row_valid;
  assign bus.row_idx   = r_row_idx;
  assign bus.row_data  = r_row_data;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_pattern_bank.sv
module tb_pattern_bank;
  localparam int DATA_W = 128;
  localparam int ROWS   = 32;
  localparam int NPAT   = 32;

  logic clka = 1'b0;
  logic rsta = 1'b0;
  int total = 0;
  int bad   = 0;

  always #5 clka = ~clka;

  pattern_bank_if #(.DATA_W(DATA_W), .ROWS(ROWS), .NPAT(NPAT)) bus ();

  pattern_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .NPAT(NPAT)) dut (
    .clka (clka),
    .rsta (rsta),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [127:0] d);
    bus.wea   = 1'b1;
    bus.addra = 10'(a);
    bus.dina  = d;
    tick();
    bus.wea   = 1'b0;
  endtask

  localparam logic [127:0] V0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] V1 = 128'hDEADBEEF_0000_0000_0000_0000_CAFEF00D;

  initial begin
    bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
    bus.start = 1'b0; bus.pat_sel = '0; bus.row_ready = 1'b0;
`ifdef PATTERN_MIRROR_EN
    bus.mirror = 1'b0;
`endif

    // 1: reset
    rsta = 1'b1;
    tick(); tick();
    chk("rst_douta", bus.douta, 0);
    chk("rst_valid", bus.row_valid, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_idx",   bus.row_idx, 0);
    chk("rst_data",  bus.row_data, 0);
    rsta = 1'b0;
    tick();
    chk("post_rst_busy", bus.busy, 0);

    // 2: port A read-first write, then read back
    wr(1, V0);
    wr(1, V1);
    chk("wr_read_first", bus.douta, V0);
    bus.addra = 10'd1;
    tick();
    chk("rd_after_wr", bus.douta, V1);

    // 3: full-throughput stream of pattern 3
    for (int i = 0; i < ROWS; i++) wr(96 + i, 128'(i));
    bus.start = 1'b1; bus.pat_sel = 5'd3; bus.row_ready = 1'b1;
    tick();
    chk("s3_busy_e0",  bus.busy, 1);
    chk("s3_valid_e0", bus.row_valid, 0);
    bus.start = 1'b0; bus.pat_sel = 5'd0;
    tick();
    for (int i = 0; i < ROWS; i++) begin
      chk("s3_valid", bus.row_valid, 1);
      chk("s3_idx",   bus.row_idx, 128'(i));
      chk("s3_data",  bus.row_data, 128'(i));
      chk("s3_done0", bus.done, 0);
      tick();
    end
    chk("s3_done",      bus.done, 1);
    chk("s3_valid_end", bus.row_valid, 0);
    tick();
    chk("s3_done_off",  bus.done, 0);
    chk("s3_busy_off",  bus.busy, 0);

    // 4: alternating ready, start pulsed mid-stream
    bus.start = 1'b1; bus.pat_sel = 5'd3; bus.row_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < ROWS; i++) begin
      chk("s4_idx",  bus.row_idx, 128'(i));
      chk("s4_data", bus.row_data, 128'(i));
      bus.row_ready = 1'b0;
      if (i == 5) begin bus.start = 1'b1; bus.pat_sel = 5'd0; end
      tick();
      bus.start = 1'b0;
      chk("s4_hold_idx",  bus.row_idx, 128'(i));
      chk("s4_hold_data", bus.row_data, 128'(i));
      chk("s4_hold_vld",  bus.row_valid, 1);
      bus.row_ready = 1'b1;
      tick();
    end
    chk("s4_done", bus.done, 1);
    bus.row_ready = 1'b0;
    tick();
    chk("s4_done_off", bus.done, 0);
    chk("s4_busy_off", bus.busy, 0);
    tick();
    chk("s4_no_requeue", bus.busy, 0);

    // 5: last pattern, no wrap; collision on row 31 fetch edge
    for (int i = 0; i < ROWS; i++) wr(992 + i, 128'(1000 + i));
    wr(0, 128'hA5A5);
    bus.start = 1'b1; bus.pat_sel = 5'd31; bus.row_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < ROWS; i++) begin
      chk("s5_idx",  bus.row_idx, 128'(i));
      chk("s5_data", bus.row_data, 128'(1000 + i));
      if (i == 30) begin bus.wea = 1'b1; bus.addra = 10'd1023; bus.dina = 128'd7777; end
      tick();
      bus.wea = 1'b0;
    end
    chk("s5_done", bus.done, 1);
    bus.addra = 10'd1023;
    tick();
    chk("s5_porta_new", bus.douta, 128'd7777);

    // 6: reset mid-stream, then restart
    bus.start = 1'b1; bus.pat_sel = 5'd3; bus.row_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("s6_idx10", bus.row_idx, 10);
    rsta = 1'b1;
    #1;
    chk("s6_rst_valid", bus.row_valid, 0);
    chk("s6_rst_busy",  bus.busy, 0);
    chk("s6_rst_idx",   bus.row_idx, 0);
    chk("s6_rst_data",  bus.row_data, 0);
    chk("s6_rst_done",  bus.done, 0);
    tick();
    rsta = 1'b0;
    tick();
    chk("s6_no_done", bus.done, 0);
    chk("s6_idle",    bus.busy, 0);
    bus.start = 1'b1; bus.pat_sel = 5'd3;
    tick();
    bus.start = 1'b0;
    tick();
    chk("s6_re_valid", bus.row_valid, 1);
    chk("s6_re_idx",   bus.row_idx, 0);
    chk("s6_re_data",  bus.row_data, 0);
    for (int i = 0; i < ROWS; i++) tick();
    chk("s6_re_done", bus.done, 1);
    tick();

`ifdef PATTERN_MIRROR_EN
    wr(96, 128'h1);
    bus.mirror = 1'b1; bus.start = 1'b1; bus.pat_sel = 5'd3;
    tick();
    bus.start = 1'b0; bus.mirror = 1'b0;
    tick();
    chk("mir_row0", bus.row_data, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    tick();
    chk("mir_row1", bus.row_data, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    for (int i = 0; i < ROWS - 1; i++) tick();
    chk("mir_done", bus.done, 1);
    bus.addra = 10'd96;
    tick();
    chk("mir_douta_plain", bus.douta, 128'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_bank.md
Name: pattern_bank

Overview:
Parametrised successor to the single-port Game of Life pattern RAM. Holds NPAT seed patterns of ROWS rows × DATA_W bits each. Keeps the random-access read/write port for host editing. Adds an independent row-streaming engine: a start request streams one whole pattern, row by row, over a valid/ready handshake to the board loader.

Parameters:
DATA_W, 128, bits per row (one board row)
ROWS, 32, rows per pattern; power of 2, >=2
NPAT, 32, number of stored patterns; power of 2, >=2
ADDR_W, 10, clog2(NPAT*ROWS); derived, not overridden
PSEL_W, 5, clog2(NPAT); derived
ROW_W, 5, clog2(ROWS); derived

Ports:
clka  in  1  clock, rising edge
rsta  in  1  asynchronous reset, active-high
wea  in  1  port A write enable
addra  in  ADDR_W  port A word address, pattern*ROWS+row
dina  in  DATA_W  port A write data
douta  out  DATA_W  port A read data, registered
start  in  1  stream request, sampled in IDLE only
pat_sel  in  PSEL_W  pattern index, captured with start
busy  out  1  stream engine active
row_valid  out  1  row_data/row_idx valid
row_ready  in  1  consumer accepts row
row_idx  out  ROW_W  row number of current row_data
row_data  out  DATA_W  streamed row
done  out  1  one-cycle pulse after last row accepted

Behaviour:
- Storage: NPAT*ROWS words of DATA_W bits, dual-port (A: read/write, B: internal stream read). rsta does not clear contents.
- Reset values: douta=0, row_data=0, row_idx=0, row_valid=0, busy=0, done=0; FSM in IDLE.
- Port A: read-first, 1-cycle latency. douta at edge N+1 = mem[addra sampled at edge N]. When wea=1, douta shows the old word.
- FSM states: IDLE, FETCH, STREAM, FIN.
- IDLE: start=1 at edge E0 captures base=pat_sel*ROWS and goes to FETCH; busy=1 from E0.
- FETCH: issues read of base+0 at edge E1, then goes to STREAM. row_valid=1 and row_idx=0 from E1, i.e. 2 edges after start was sampled.
- STREAM, handshake (row_valid&&row_ready) at an edge, not last row: read base+row_idx+1 on that same edge; row_idx increments and row_valid stays 1. Full throughput is one row per cycle.
- STREAM, stall (row_ready=0): row_data and row_idx held stable, no memory read issued.
- STREAM, handshake on row_idx=ROWS-1: row_valid drops and the FSM goes to FIN.
- FIN: done=1 for exactly that one cycle; busy drops with done. Next edge returns to IDLE.
- start while busy is ignored (not queued). pat_sel changes after capture have no effect.
- Address never wraps across patterns. pat_sel=NPAT-1 reads the final ROWS words exactly.
- Collision: port A write to the word fetched by port B on the same edge gives the stream the old data (read-first). Writes to later rows of the active pattern are seen when those rows are fetched.
- rsta mid-stream: all outputs immediately go to reset values, FSM to IDLE, no done pulse. A subsequent start restarts at row 0.
- Port A activity never stalls or perturbs the stream, and vice versa.

Optional Feature:
PATTERN_MIRROR_EN
- Defined: extra input port mirror (1 bit), captured with start. When the captured value is 1, row_data is the bit-reversed stored row (row_data[i]=mem[DATA_W-1-i]), giving a horizontal flip. Reversal is applied at the stream output register, so latency is unchanged. douta is never mirrored.
- Undefined: no mirror port; row_data is always the stored word unmodified.

Test Plan:
1. Assert rsta for 2 cycles -> douta=0, row_valid=0, busy=0, done=0, row_idx=0.
2. wea=1, addra=1, dina=128'hDEADBEEF_0000_0000_0000_0000_CAFEF00D; then wea=0, addra=1 -> douta equals that value one edge later. Write cycle douta shows the prior contents of addr 1.
3. Fill addr 96..127 with data=row number; start=1, pat_sel=3, row_ready=1 -> row_valid rises 2 edges after start. row_idx/row_data 0..31 on 32 consecutive cycles; done one cycle after row 31 accepted; busy low after done.
4. Same stream with row_ready alternating 1,0 -> each row held stable while ready=0, no rows skipped or duplicated, done after 32 handshakes. start pulsed mid-stream is ignored.
5. pat_sel=31, addr 992..1023 holding 1000+i -> rows 1000..1031 streamed, no wrap into addr 0. Port A write to addr 1023 on the fetch edge of row 31 -> stream gets the old value.
6. Assert rsta while row_idx=10 -> row_valid, busy drop immediately, no done. New start pat_sel=3 -> stream restarts at row_idx=0. With PATTERN_MIRROR_EN and mirror=1, row holding 128'h1 streams as 128'h8000...0.
